// File: rtl/quiz_pkg.sv
// Shared types and constants for the buzzer round controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package quiz_pkg;

    // Round state, 2-bit encoding visible on the state output.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ANSWER = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int N_DEFAULT = 4;    // contestants on this board
    localparam int SCORE_W   = 4;    // bits per contestant score
    localparam int SCORE_MAX = 15;   // saturation value of a score

endpackage

// File: rtl/quiz_round_ctrl_if.sv
// Bundle of contestant/host pulses and round status between the front end and the controller.
// Latency: n/a (wires only).
// Backpressure: none; all signals are single-cycle pulses or registered status.
// Ports: master drives buzz/host_* and observes status; slave is the controller.
interface quiz_round_ctrl_if import quiz_pkg::*; #(parameter int N = N_DEFAULT);

    logic [N-1:0]         buzz;
    logic                 host_start;
    logic                 host_correct;
    logic                 host_wrong;
    logic                 host_clear;
    state_t               state;
    logic [N-1:0]         winner;
    logic [N-1:0]         lockout;
    logic [7:0]           time_left;
    logic                 timeout;
    logic                 round_over;
    logic [SCORE_W*N-1:0] score;

    modport master (
        output buzz, host_start, host_correct, host_wrong, host_clear,
        input  state, winner, lockout, time_left, timeout, round_over, score
    );

    modport slave (
        input  buzz, host_start, host_correct, host_wrong, host_clear,
        output state, winner, lockout, time_left, timeout, round_over, score
    );

endinterface

// File: rtl/quiz_round_ctrl_answer_timer.sv
// Answer countdown: prescaler divides clk into ticks, time_left counts ticks down from ANSWER_TICKS.
// Latency: load/clear take effect on the next edge; expire is asserted combinationally in the final-tick cycle.
// Backpressure: none; counting runs only while en is high, otherwise both counters sit at zero.
// Ports: clk, rst, load (start countdown), en (count this cycle), time_left, expire.
module answer_timer #(
    parameter int TICK_DIV     = 5_000_000,
    parameter int ANSWER_TICKS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    output logic [7:0] time_left,
    output logic       expire
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] pre_q;
    logic [7:0]    tl_q;
    logic          tick;

    assign tick      = en && (pre_q == PW'(TICK_DIV - 1));
    assign expire    = tick && (tl_q == 8'd1);
    assign time_left = tl_q;

    // Dropping en zeroes the counter in the same edge the controller leaves ANSWER,
    // so time_left reads 0 as soon as the answer is resolved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            tl_q  <= '0;
        end else if (load) begin
            pre_q <= '0;
            tl_q  <= 8'(ANSWER_TICKS);
        end else if (!en) begin
            pre_q <= '0;
            tl_q  <= '0;
        end else if (tick) begin
            pre_q <= '0;
            tl_q  <= tl_q - 8'd1;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

endmodule

// File: rtl/quiz_round_ctrl.sv
// Buzzer round controller: arbitrates buzzes, runs the answer timer, tracks lockouts and scores.
// Latency: one cycle from buzz/host pulse to registered outputs.
// Backpressure: none; buzzes outside ARMED and host pulses invalid for the state are dropped.
// Ports: clk, rst (async, active-high), bus (slave side of quiz_round_ctrl_if).
module quiz_round_ctrl import quiz_pkg::*; #(
    parameter int N            = N_DEFAULT,
    parameter int TICK_DIV     = 5_000_000,
    parameter int ANSWER_TICKS = 100
) (
    input  logic            clk,
    input  logic            rst,
    quiz_round_ctrl_if.slave bus
);

    state_t               state_q, state_d;
    logic [N-1:0]         winner_q, winner_d;
    logic [N-1:0]         lockout_q, lockout_d;
    logic                 timeout_q, timeout_d;
    logic                 round_over_q, round_over_d;
    logic [SCORE_W*N-1:0] score_q, score_d;

    logic [N-1:0] eligible;
    logic [N-1:0] pick;
    logic [N-1:0] lock_after;
    logic         tmr_load;
    logic         tmr_en;
    logic         tmr_expire;
    logic [7:0]   tmr_left;

    // Isolate the lowest set bit: lowest-index eligible contestant wins ties.
    assign eligible   = bus.buzz & ~lockout_q;
    assign pick       = eligible & (~eligible + N'(1));
    assign lock_after = lockout_q | winner_q;

    assign tmr_load = (state_q == ST_ARMED) && (eligible != '0) && !bus.host_clear;
    // Any host decision ends the answer this edge, so the timer must stop counting now.
    assign tmr_en   = (state_q == ST_ANSWER) && !bus.host_clear
                      && !bus.host_correct && !bus.host_wrong;

    answer_timer #(
        .TICK_DIV     (TICK_DIV),
        .ANSWER_TICKS (ANSWER_TICKS)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .en        (tmr_en),
        .time_left (tmr_left),
        .expire    (tmr_expire)
    );

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        lockout_d    = lockout_q;
        timeout_d    = 1'b0;
        round_over_d = 1'b0;
        score_d      = score_q;

        if (bus.host_clear) begin
            state_d   = ST_IDLE;
            winner_d  = '0;
            lockout_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.host_start) begin
                        lockout_d = '0;
                        state_d   = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (eligible != '0) begin
                        winner_d = pick;
                        state_d  = ST_ANSWER;
                    end
                end
                ST_ANSWER: begin
                    if (bus.host_correct) begin
                        for (int i = 0; i < N; i++) begin
                            if (winner_q[i] && (score_q[i*SCORE_W +: SCORE_W] != SCORE_W'(SCORE_MAX)))
                                score_d[i*SCORE_W +: SCORE_W] = score_q[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
                        end
                        state_d = ST_DONE;
                    end else if (bus.host_wrong || tmr_expire) begin
                        lockout_d = lock_after;
                        winner_d  = '0;
                        timeout_d = !bus.host_wrong;
                        if (&lock_after) begin
                            round_over_d = 1'b1;
                            state_d      = ST_IDLE;
                        end else begin
                            state_d = ST_ARMED;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.host_start) begin
                        lockout_d = '0;
                        winner_d  = '0;
                        state_d   = ST_ARMED;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            winner_q     <= '0;
            lockout_q    <= '0;
            timeout_q    <= 1'b0;
            round_over_q <= 1'b0;
            score_q      <= '0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            lockout_q    <= lockout_d;
            timeout_q    <= timeout_d;
            round_over_q <= round_over_d;
            score_q      <= score_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.winner     = winner_q;
    assign bus.lockout    = lockout_q;
    assign bus.time_left  = tmr_left;
    assign bus.timeout    = timeout_q;
    assign bus.round_over = round_over_q;
    assign bus.score      = score_q;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Directed bench for quiz_round_ctrl with TICK_DIV=4, ANSWER_TICKS=3.
// Latency: inputs driven at negedge, outputs sampled at the following negedge.
// Backpressure: n/a.
module tb_quiz_round_ctrl;
    import quiz_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   failed;

    quiz_round_ctrl_if #(.N(4)) bus();

    quiz_round_ctrl #(
        .N            (4),
        .TICK_DIV     (4),
        .ANSWER_TICKS (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  buzz;
        logic        start;
        logic        correct;
        logic        wrong;
        logic        clear;
        logic [1:0]  e_state;
        logic [3:0]  e_win;
        logic [3:0]  e_lock;
        logic [7:0]  e_tl;
        logic        e_to;
        logic        e_ro;
        logic [15:0] e_score;
    } vec_t;

    vec_t tbl [30];

    function automatic vec_t mk(input logic [3:0] b, input logic s, input logic c,
                                input logic w, input logic cl, input logic [1:0] es,
                                input logic [3:0] ew, input logic [3:0] el,
                                input logic [7:0] et, input logic eto, input logic ero,
                                input logic [15:0] esc);
        vec_t r;
        r = '{b, s, c, w, cl, es, ew, el, et, eto, ero, esc};
        return r;
    endfunction

    // One clock: hold inputs across the posedge, return at the next negedge with pulses dropped.
    task automatic step(input logic [3:0] b, input logic s, input logic c,
                        input logic w, input logic cl);
        bus.buzz         = b;
        bus.host_start   = s;
        bus.host_correct = c;
        bus.host_wrong   = w;
        bus.host_clear   = cl;
        @(negedge clk);
        bus.buzz         = 4'b0;
        bus.host_start   = 1'b0;
        bus.host_correct = 1'b0;
        bus.host_wrong   = 1'b0;
        bus.host_clear   = 1'b0;
    endtask

    task automatic check(input string nm, input logic [1:0] es, input logic [3:0] ew,
                         input logic [3:0] el, input logic [7:0] et, input logic eto,
                         input logic ero, input logic [15:0] esc);
        logic [35:0] act;
        logic [35:0] exp;
        act = {bus.state, bus.winner, bus.lockout, bus.time_left, bus.timeout, bus.round_over, bus.score};
        exp = {es, ew, el, et, eto, ero, esc};
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got st=%0d win=%b lock=%b tl=%0d to=%b ro=%b score=%h, want st=%0d win=%b lock=%b tl=%0d to=%b ro=%b score=%h",
                     nm, bus.state, bus.winner, bus.lockout, bus.time_left, bus.timeout,
                     bus.round_over, bus.score, es, ew, el, et, eto, ero, esc);
        end
    endtask

    task automatic check_val(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        tests  = 0;
        failed = 0;

        //               buzz     st    cor   wr    clr   state  win      lock     tl    to    ro    score
        tbl[0]  = mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 16'h0000);
        tbl[1]  = mk(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0100, 4'b0000, 8'd3, 1'b0, 1'b0, 16'h0000);
        tbl[2]  = mk(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0100, 4'b0000, 8'd0, 1'b0, 1'b0, 16'h0100);
        tbl[3]  = mk(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0100, 4'b0000, 8'd0, 1'b0, 1'b0, 16'h0100);
        tbl[4]  = mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 16'h0100);
        tbl[5]  = mk(4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0010, 4'b0000, 8'd3, 1'b0, 1'b0, 16'h0100);
        tbl[6]  = mk(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0010, 4'b0000, 8'd3, 1'b0, 1'b0, 16'h0100);
        tbl[7]  = mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0000, 4'b0010, 8'd0, 1'b0, 1'b0, 16'h0100);
        tbl[8]  = mk(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0010, 8'd0, 1'b0, 1'b0, 16'h0100);
        tbl[9]  = mk(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0100, 4'b0010, 8'd3, 1'b0, 1'b0, 16'h0100);
        tbl[10] = mk(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 4'b0100, 4'b0010, 8'd0, 1'b0, 1'b0, 16'h0200);
        tbl[11] = mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0100, 4'b0010, 8'd0, 1'b0, 1'b0, 16'h0200);
        tbl[12] = mk(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0100, 4'b0010, 8'd0, 1'b0, 1'b0, 16'h0200);
        tbl[13] = mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 16'h0200);
        tbl[14] = mk(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 16'h0200);
        tbl[15] = mk(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 16'h0200);
        tbl[16] = mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 16'h0200);
        tbl[17] = mk(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b1000, 4'b0000, 8'd3, 1'b0, 1'b0, 16'h0200);
        tbl[18] = mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0000, 4'b1000, 8'd0, 1'b0, 1'b0, 16'h0200);
        tbl[19] = mk(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0100, 4'b1000, 8'd3, 1'b0, 1'b0, 16'h0200);
        tbl[20] = mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0000, 4'b1100, 8'd0, 1'b0, 1'b0, 16'h0200);
        tbl[21] = mk(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0010, 4'b1100, 8'd3, 1'b0, 1'b0, 16'h0200);
        tbl[22] = mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0000, 4'b1110, 8'd0, 1'b0, 1'b0, 16'h0200);
        tbl[23] = mk(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0001, 4'b1110, 8'd3, 1'b0, 1'b0, 16'h0200);
        tbl[24] = mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b1111, 8'd0, 1'b0, 1'b1, 16'h0200);
        tbl[25] = mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b1111, 8'd0, 1'b0, 1'b0, 16'h0200);
        tbl[26] = mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 16'h0200);
        tbl[27] = mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 16'h0200);
        tbl[28] = mk(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0010, 4'b0000, 8'd3, 1'b0, 1'b0, 16'h0200);
        tbl[29] = mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 16'h0200);

        rst              = 1'b1;
        bus.buzz         = 4'b0;
        bus.host_start   = 1'b0;
        bus.host_correct = 1'b0;
        bus.host_wrong   = 1'b0;
        bus.host_clear   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset", 2'd0, 4'b0, 4'b0, 8'd0, 1'b0, 1'b0, 16'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle", 2'd0, 4'b0, 4'b0, 8'd0, 1'b0, 1'b0, 16'h0);

        for (int i = 0; i < 30; i++) begin
            step(tbl[i].buzz, tbl[i].start, tbl[i].correct, tbl[i].wrong, tbl[i].clear);
            check($sformatf("vec%0d", i), tbl[i].e_state, tbl[i].e_win, tbl[i].e_lock,
                  tbl[i].e_tl, tbl[i].e_to, tbl[i].e_ro, tbl[i].e_score);
        end

        // Timer expiry: timeout must land exactly 3 ticks * 4 cycles after ANSWER entry.
        step(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        check("to_entry", 2'd2, 4'b0001, 4'b0000, 8'd3, 1'b0, 1'b0, 16'h0200);
        seen = 0;
        for (int k = 1; k <= 20 && seen == 0; k++) begin
            step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
            if (bus.timeout) seen = k;
            if (k == 4)  check_val("to_tl_at4", int'(bus.time_left), 2);
            if (k == 11) check_val("to_tl_at11", int'(bus.time_left), 1);
        end
        check_val("to_cycle", seen, 12);
        check("to_expired", 2'd1, 4'b0000, 4'b0001, 8'd0, 1'b1, 1'b0, 16'h0200);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        check("to_pulse_end", 2'd1, 4'b0000, 4'b0001, 8'd0, 1'b0, 1'b0, 16'h0200);
        step(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        check("to_locked_buzz", 2'd1, 4'b0000, 4'b0001, 8'd0, 1'b0, 1'b0, 16'h0200);
        step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        check("to_rearm", 2'd2, 4'b0100, 4'b0001, 8'd3, 1'b0, 1'b0, 16'h0200);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        check("to_clear", 2'd0, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 16'h0200);

        // Saturation of contestant 1 over sixteen correct answers.
        step(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            step(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
            step(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 1)  check_val("sat_first", int'(bus.score[7:4]), 1);
            if (i == 15) check_val("sat_15", int'(bus.score[7:4]), 15);
            if (i == 16) check_val("sat_16", int'(bus.score[7:4]), 15);
            step(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        step(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_answer", 2'd2, 4'b0010, 4'b0000, 8'd3, 1'b0, 1'b0, 16'h02F0);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clear_mid_answer", 2'd0, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 16'h02F0);

        // Asynchronous reset in the middle of an answer.
        step(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_rst_answer", 2'd2, 4'b0001, 4'b0000, 8'd3, 1'b0, 1'b0, 16'h02F0);
        rst = 1'b1;
        #1;
        check("async_rst", 2'd0, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        step(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        check("after_rst_idle", 2'd0, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/quiz_round_ctrl.md
# quiz_round_ctrl

Round controller and arbiter for the 4-contestant buzzer system. Takes debounced single-cycle buzz pulses from the key/IO scan front end and host control pulses, and grants the answer to exactly one contestant. Runs a per-answer countdown, locks out contestants who answer wrongly or time out, re-arms for the rest, and keeps per-contestant scores. Sits between the scan/edge-detect stage and the LED/display drivers, clocked by the 50 MHz PLL clock.

## Interface
- N, 4: number of contestants. Fixed at 4 for this board; generic for sim.
- TICK_DIV, 5_000_000: clk cycles per timer tick (0.1 s at 50 MHz). Must be ≥2.
- ANSWER_TICKS, 100: ticks allowed per answer. Must be 1..255.
- clk  in  1  system clock (50 MHz PLL output)
- rst  in  1  asynchronous, active-high reset
- buzz  in  N  contestant buzz pulses, one cycle each, already debounced/edge-detected
- host_start  in  1  pulse: open a new round
- host_correct  in  1  pulse: current answer judged correct
- host_wrong  in  1  pulse: current answer judged wrong
- host_clear  in  1  pulse: abort round, return to IDLE (scores kept)
- state  out  2  IDLE=0, ARMED=1, ANSWER=2, DONE=3
- winner  out  N  one-hot current answerer; 0 when none
- lockout  out  N  contestants barred for the rest of this round
- time_left  out  8  remaining ticks in ANSWER; 0 otherwise
- timeout  out  1  one-cycle pulse when the answer timer expires
- round_over  out  1  one-cycle pulse when all contestants are locked out
- score  out  4*N  packed 4-bit saturating scores; contestant i at [4i+3:4i]

## Operation
- IDLE: winner=0, time_left=0. host_start clears lockout and moves to ARMED. Buzzes are ignored.
- ARMED: eligible = buzz & ~lockout. If nonzero, the lowest-index eligible contestant wins. winner is set one-hot, time_left loads ANSWER_TICKS, the prescaler clears, and the state moves to ANSWER.
- ANSWER: all buzzes are ignored. The prescaler counts 0..TICK_DIV-1 and ticks at TICK_DIV-1. Each tick decrements time_left.
  - host_correct: score[winner] increments, saturating at 15. State moves to DONE; winner is held.
  - host_wrong, or a tick with time_left==1: winner's lockout bit is set, winner clears, time_left goes to 0. timeout pulses on expiry only.
  - After a lockout, if every bit of lockout is 1: round_over pulses and the state moves to IDLE. Otherwise the state moves to ARMED.
- DONE: winner is held for display. host_start begins a new round: clears lockout and winner, moves to ARMED.
- host_clear in any state: winner=0, lockout=0, time_left=0, state to IDLE. Scores are unchanged.
- Simultaneous host pulses are resolved by priority: host_clear > host_correct > host_wrong > timer expiry.
- host_start outside IDLE/DONE is ignored. host_correct/host_wrong outside ANSWER are ignored.
- Reset values: state=IDLE, winner=0, lockout=0, time_left=0, timeout=0, round_over=0, all scores=0, prescaler=0.

## Timing
- Buzz at cycle t in ARMED: state=ANSWER, winner and time_left=ANSWER_TICKS are visible at t+1.
- Expiry: the timeout pulse, lockout update and state change occur ANSWER_TICKS*TICK_DIV cycles after ANSWER entry.
- Host pulse at cycle t: result is visible at t+1. Score updates in the same edge as DONE entry.
- A buzz arriving in the same cycle the state re-enters ARMED is not seen. A buzz is only seen while state==ARMED.
- rst asserted mid-ANSWER: all outputs return to reset values immediately (asynchronous), including scores.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package quiz_pkg holds:
  - the state enum and its 2-bit encoding;
  - the default N;
  - SCORE_W=4 and the saturation constant 15.
- One sub-module, answer_timer, holds the prescaler and time_left down-counter.
  - Inputs: load, tick enable.
  - Outputs: time_left, expire.
- Arbitration (priority encode) and the FSM stay in quiz_round_ctrl.

## Test plan
All scenarios use TICK_DIV=4, ANSWER_TICKS=3.
- Reset, host_start, buzz=0100 → next cycle state=2, winner=0100, time_left=3; host_correct → state=3, score[2]=1.
- Simultaneous buzz=1010 in ARMED → winner=0010. buzz=1111 during ANSWER → winner unchanged.
- No host pulse after a win by contestant 0 → timeout pulses exactly 12 cycles after ANSWER entry; lockout=0001, state=1; a later buzz=0001 is ignored.
- host_wrong for 3, then 2, then 1, then 0 → round_over pulses after the fourth; state=0, lockout=1111.
- Sixteen correct answers by contestant 1 → score[1] saturates at 15. host_clear mid-ANSWER → state=0, winner=0, scores kept.
- host_correct and host_wrong in the same cycle → correct wins. rst asserted mid-ANSWER → all outputs are 0 before the next clk edge.
